mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one physical memory port between the instruction
// and data caches; alternates grants under contention and inserts a release cycle.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,

    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,

    output logic                  arb_busy
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;

    state_t                state, state_next;
    grant_t                last_grant, last_grant_next;
    logic                  grant_i, grant_d;
    logic                  i_req, d_req;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  write_q;

    assign i_req = icache_pmem_read;
    assign d_req = dcache_pmem_read | dcache_pmem_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next       = state;
        last_grant_next  = last_grant;
        grant_i          = 1'b0;
        grant_d          = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;
        unique case (state)
            IDLE: begin
                // Under contention the side that did not win last time goes first.
                if (i_req && (!d_req || last_grant == GRANT_D)) begin
                    grant_i         = 1'b1;
                    state_next      = SERVE_I;
                    last_grant_next = GRANT_I;
                end else if (d_req) begin
                    grant_d         = 1'b1;
                    state_next      = SERVE_D;
                    last_grant_next = GRANT_D;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    icache_pmem_resp = 1'b1;
                    state_next       = RELEASE;
                end
            end
            SERVE_D: begin
                pmem_read  = ~write_q;
                pmem_write = write_q;
                if (pmem_resp) begin
                    dcache_pmem_resp = 1'b1;
                    state_next       = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction is frozen at grant so requester changes mid-service are invisible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (grant_i) begin
            addr_q  <= icache_pmem_address;
            wdata_q <= dcache_pmem_wdata;
            write_q <= 1'b0;
        end else if (grant_d) begin
            addr_q  <= dcache_pmem_address;
            wdata_q <= dcache_pmem_wdata;
            write_q <= dcache_pmem_write;
        end
    end

    assign pmem_address      = addr_q;
    assign pmem_wdata        = wdata_q;
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;
    assign arb_busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk;
    logic          reset_n;
    logic          icache_pmem_read;
    logic [AW-1:0] icache_pmem_address;
    logic [LW-1:0] icache_pmem_rdata;
    logic          icache_pmem_resp;
    logic          dcache_pmem_read;
    logic          dcache_pmem_write;
    logic [AW-1:0] dcache_pmem_address;
    logic [LW-1:0] dcache_pmem_wdata;
    logic [LW-1:0] dcache_pmem_rdata;
    logic          dcache_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          arb_busy;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset_n(reset_n),
        .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
        .icache_pmem_rdata(icache_pmem_rdata), .icache_pmem_resp(icache_pmem_resp),
        .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
        .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
        .dcache_pmem_rdata(dcache_pmem_rdata), .dcache_pmem_resp(dcache_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .arb_busy(arb_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: who owns memory (0 none, 1 icache, 2 dcache), whether
    // the post-completion quiet cycle is pending, and the frozen transaction.
    int            m_owner;
    bit            m_quiet;
    bit            m_last_d;
    int            m_svc;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    bit            m_write;

    bit  auto_mem, auto_drop, rand_rdata;
    int  mem_lat;
    int  cyc;
    int  n_rd, n_wr, n_iresp, n_dresp;
    bit  prev_cmd;
    logic [LW-1:0] i_data_seen;
    byte resp_log[$];
    int  resp_cyc[$];
    int  cmd_starts[$];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_quiet = 0; m_last_d = 0; m_svc = 0;
        m_addr = '0; m_wdata = '0; m_write = 0;
    endtask

    task automatic check_outputs();
        chk("busy",      LW'(arb_busy),     LW'(m_owner != 0 || m_quiet));
        chk("pmem_read", LW'(pmem_read),    LW'(m_owner == 1 || (m_owner == 2 && !m_write)));
        chk("pmem_write", LW'(pmem_write),  LW'(m_owner == 2 && m_write));
        chk("pmem_addr", LW'(pmem_address), LW'(m_addr));
        chk("pmem_wdata", pmem_wdata,       m_wdata);
        chk("i_resp",    LW'(icache_pmem_resp), LW'(m_owner == 1 && pmem_resp));
        chk("d_resp",    LW'(dcache_pmem_resp), LW'(m_owner == 2 && pmem_resp));
        chk("i_rdata",   icache_pmem_rdata, pmem_rdata);
        chk("d_rdata",   dcache_pmem_rdata, pmem_rdata);
    endtask

    task automatic model_edge();
        bit ireq, dreq, take_d;
        if (m_quiet) begin
            m_quiet = 0;
        end else if (m_owner != 0) begin
            if (pmem_resp) begin
                m_owner = 0;
                m_quiet = 1;
            end else begin
                m_svc++;
            end
        end else begin
            ireq = icache_pmem_read;
            dreq = dcache_pmem_read | dcache_pmem_write;
            if (ireq || dreq) begin
                take_d   = dreq && (!ireq || !m_last_d);
                m_owner  = take_d ? 2 : 1;
                m_last_d = take_d;
                m_svc    = 0;
                m_addr   = take_d ? dcache_pmem_address : icache_pmem_address;
                m_write  = take_d && dcache_pmem_write;
                m_wdata  = dcache_pmem_wdata;
            end
        end
    endtask

    task automatic tick();
        bit fired_i, fired_d, cmd;
        @(negedge clk);
        check_outputs();
        fired_i = (m_owner == 1) && pmem_resp;
        fired_d = (m_owner == 2) && pmem_resp;
        cmd = pmem_read | pmem_write;
        if (cmd && !prev_cmd) cmd_starts.push_back(cyc);
        prev_cmd = cmd;
        if (pmem_read)  n_rd++;
        if (pmem_write) n_wr++;
        if (icache_pmem_resp) begin
            n_iresp++; resp_log.push_back("I"); resp_cyc.push_back(cyc);
            i_data_seen = icache_pmem_rdata;
        end
        if (dcache_pmem_resp) begin
            n_dresp++; resp_log.push_back("D"); resp_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (auto_drop && fired_i) icache_pmem_read = 1'b0;
        if (auto_drop && fired_d) begin
            dcache_pmem_read  = 1'b0;
            dcache_pmem_write = 1'b0;
        end
        if (rand_rdata) pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (auto_mem) pmem_resp = (m_owner != 0) && (m_svc == mem_lat - 1);
    endtask

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; n_iresp = 0; n_dresp = 0; prev_cmd = 0;
        resp_log.delete(); resp_cyc.delete(); cmd_starts.delete();
    endtask

    task automatic do_reset();
        icache_pmem_read = 0; dcache_pmem_read = 0; dcache_pmem_write = 0;
        icache_pmem_address = '0; dcache_pmem_address = '0; dcache_pmem_wdata = '0;
        pmem_resp = 0;
        reset_n = 0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        reset_n = 1;
        clear_stats();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1; cyc = 0; pmem_rdata = '0; i_data_seen = '0;
        auto_mem = 0; auto_drop = 1; rand_rdata = 1; mem_lat = 2;
        model_reset();
        clear_stats();
        #2;
        do_reset();

        // Lone icache fill, 4-cycle memory latency, fixed data pattern.
        rand_rdata = 0; pmem_rdata = {16{8'hA5}};
        auto_mem = 1; mem_lat = 4;
        icache_pmem_read = 1; icache_pmem_address = 16'h1230;
        for (int k = 0; k < 30 && n_iresp == 0; k++) tick();
        tick(); tick();
        chk("i_fill_read_cycles", LW'(n_rd), LW'(4));
        chk("i_fill_resp_count", LW'(n_iresp), LW'(1));
        chk("i_fill_d_resp", LW'(n_dresp), LW'(0));
        chk("i_fill_data", i_data_seen, {16{8'hA5}});
        rand_rdata = 1;

        // Simultaneous requests right after reset: dcache wins, then icache.
        do_reset();
        auto_mem = 1; mem_lat = 2;
        icache_pmem_read = 1; icache_pmem_address = 16'h0100;
        dcache_pmem_read = 1; dcache_pmem_address = 16'h0200;
        for (int k = 0; k < 40 && (n_iresp + n_dresp) < 2; k++) tick();
        tick();
        chk("both_count", LW'(resp_log.size() >= 2 && cmd_starts.size() >= 2), LW'(1));
        if (resp_log.size() >= 2 && cmd_starts.size() >= 2) begin
            chk("both_first", LW'(resp_log[0]), LW'(8'h44));
            chk("both_second", LW'(resp_log[1]), LW'(8'h49));
            chk("both_gap", LW'(cmd_starts[1] - resp_cyc[0]), LW'(3));
        end

        // Writeback with requester address/data changing mid-service.
        do_reset();
        auto_mem = 1; mem_lat = 5;
        dcache_pmem_write = 1; dcache_pmem_address = 16'h4000; dcache_pmem_wdata = {32{4'h1}};
        tick(); tick(); tick();
        dcache_pmem_address = 16'h5000; dcache_pmem_wdata = {32{4'hE}};
        for (int k = 0; k < 30 && n_dresp == 0; k++) tick();
        tick();
        chk("wb_write_cycles", LW'(n_wr), LW'(5));
        chk("wb_read_cycles", LW'(n_rd), LW'(0));
        chk("wb_resp", LW'(n_dresp), LW'(1));

        // Read and write both raised by dcache: the write wins.
        do_reset();
        auto_mem = 1; mem_lat = 2;
        dcache_pmem_read = 1; dcache_pmem_write = 1; dcache_pmem_address = 16'h0ABC;
        dcache_pmem_wdata = {4{32'hDEADBEEF}};
        for (int k = 0; k < 20 && n_dresp == 0; k++) tick();
        chk("rw_write_cycles", LW'(n_wr), LW'(2));
        chk("rw_read_cycles", LW'(n_rd), LW'(0));

        // Sustained contention: six grants alternate starting with dcache.
        do_reset();
        auto_mem = 1; mem_lat = 2; auto_drop = 0;
        icache_pmem_read = 1; dcache_pmem_read = 1;
        for (int k = 0; k < 100 && resp_log.size() < 6; k++) tick();
        auto_drop = 1;
        chk("alt_count", LW'(resp_log.size() >= 6), LW'(1));
        for (int k = 0; k < 6 && k < resp_log.size(); k++)
            chk("alt_order", LW'(resp_log[k]), (k % 2 == 0) ? LW'(8'h44) : LW'(8'h49));

        // Reset asserted while icache is being served.
        do_reset();
        auto_mem = 1; mem_lat = 10;
        icache_pmem_read = 1; icache_pmem_address = 16'h2222;
        tick(); tick(); tick();
        #2;
        reset_n = 0;
        #1;
        chk("rst_mid_read", LW'(pmem_read), LW'(0));
        chk("rst_mid_busy", LW'(arb_busy), LW'(0));
        chk("rst_mid_addr", LW'(pmem_address), LW'(0));
        model_reset();
        icache_pmem_read = 0; auto_mem = 0; pmem_resp = 1;
        @(posedge clk);
        #1;
        reset_n = 1;
        clear_stats();
        for (int k = 0; k < 5; k++) tick();
        chk("rst_no_resp", LW'(n_iresp + n_dresp), LW'(0));

        // Spurious memory response while idle.
        do_reset();
        auto_mem = 0; pmem_resp = 1;
        tick(); tick(); tick();
        pmem_resp = 0;
        chk("spurious_resp", LW'(n_iresp + n_dresp), LW'(0));
        chk("spurious_busy", LW'(arb_busy), LW'(0));

        // Random traffic with random memory responses, including spurious ones.
        do_reset();
        auto_mem = 0; auto_drop = 1;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (!icache_pmem_read && $urandom_range(2) == 0) begin
                icache_pmem_read = 1; icache_pmem_address = AW'($urandom);
            end
            if (!dcache_pmem_read && !dcache_pmem_write && $urandom_range(2) == 0) begin
                dcache_pmem_read  = 1'($urandom);
                dcache_pmem_write = ~dcache_pmem_read | 1'($urandom);
                dcache_pmem_address = AW'($urandom);
                dcache_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if ($urandom_range(7) == 0) icache_pmem_address = AW'($urandom);
            if ($urandom_range(7) == 0) dcache_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            pmem_resp = ($urandom_range(3) == 0);
        end
        pmem_resp = 0;
        chk("rand_activity", LW'(n_iresp > 0 && n_dresp > 0), LW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
